wb_stage: RTL
=============

Name: wb_stage

Overview:
- Write-back stage. Holds the MEM/WB pipeline register and extracts and sign-extends load data.
- Selects the write-back source and drives the single register-file write port (wb_reg_write/wb_rd_addr/wb_data) consumed by the decode stage.
- Arbitrates that port between in-order pipeline results and out-of-order results from the multi-cycle divider, buffered in a small FIFO.
- Raises a pipeline stall when divider results starve.

Parameters:
- XLEN, 32, datapath width.
- LQ_DEPTH, 2, divider result FIFO depth (power of 2, >=2).
- STARVE_LIMIT, 4, consecutive starved cycles before a forced drain.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_valid_i  in  1  MEM stage holds a valid instruction
- mem_reg_write_i  in  1  instruction writes rd
- mem_rd_addr_i  in  5  destination register
- mem_to_reg_i  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 ALU
- mem_alu_result_i  in  XLEN  ALU result / effective address
- mem_rdata_i  in  XLEN  raw aligned data-memory word
- mem_pc_plus_4_i  in  XLEN  link value
- mem_funct3_i  in  3  load type
- div_valid_i  in  1  divider offers a result
- div_rd_addr_i  in  5  divider destination
- div_result_i  in  XLEN  divider result
- div_ready_o  out  1  FIFO accepts the divider result this cycle
- stall_o  out  1  freeze IF..MEM and the MEM/WB register
- wb_reg_write_o  out  1  register-file write enable (also the forwarding source)
- wb_rd_addr_o  out  5  write address
- wb_data_o  out  XLEN  write data

Behaviour:
- Reset: MEM/WB valid=0, FIFO empty, starve_cnt=0, state=NORMAL. wb_reg_write_o=0, wb_rd_addr_o=0, wb_data_o=0, stall_o=0. div_ready_o=0 while rst is high.
- MEM/WB register: captures all mem_* inputs on each edge when stall_o=0 and holds when stall_o=1. Pipeline latency is one cycle, MEM input to write port.
- Load extract uses alu_result[1:0]:
  - LB 000 / LBU 100: byte at [1:0], sign- or zero-extended.
  - LH 001 / LHU 101: halfword at bit [1], sign- or zero-extended.
  - LW 010: whole word.
  - Any other funct3: whole word.
- Result mux: 00 ALU, 01 extracted load, 10 PC+4, 11 ALU.
- pipe_wr = MEM/WB valid & reg_write & rd!=0.
- Write port, combinational from registered state:
  - NORMAL & pipe_wr: pipeline result.
  - Else, FIFO non-empty: FIFO head, popped this cycle.
  - Else: wb_reg_write_o=0, address and data driven 0.
- Writes to x0 are never issued. A divider result with rd=0 is accepted and discarded, never pushed.
- FIFO:
  - div_ready_o = !full & state==NORMAL & !rst.
  - Push on div_valid_i & div_ready_o.
  - Push and pop in the same cycle leaves occupancy unchanged.
  - No bypass: an accepted result writes no earlier than the next cycle.
  - Pointers wrap modulo LQ_DEPTH.
- starve_cnt: incremented in NORMAL when pipe_wr=1 and the FIFO is non-empty, otherwise cleared.
- NORMAL -> DRAIN: at the edge where the incremented starve_cnt equals STARVE_LIMIT, or where FIFO is full & pipe_wr. starve_cnt clears on entry.
- DRAIN:
  - stall_o=1 and div_ready_o=0.
  - One FIFO entry is written per cycle; the held MEM/WB instruction is not written.
  - DRAIN -> NORMAL at the edge where the last entry pops.
  - The held instruction writes in the first NORMAL cycle, exactly once. The instruction retired on the transition cycle is not repeated.
  - DRAIN length equals FIFO occupancy at entry.
- rst mid-DRAIN or with a non-empty FIFO: all entries are discarded and the block returns to reset values next cycle.
- WAW ordering between divider and pipeline writes to the same rd is guaranteed by the issue/hazard logic and is not checked here.

Test Plan:
- ALU op rd=5, alu=0x1234 -> wb_reg_write_o=1, rd=5, data=0x00001234 one cycle later.
- Loads from rdata=0x80FF7F01:
  - LB addr_lo=1 -> 0x0000007F.
  - LB addr_lo=2 -> 0xFFFFFFFF.
  - LBU addr_lo=3 -> 0x00000080.
  - LH addr_lo=2 -> 0xFFFF80FF.
  - LHU addr_lo=0 -> 0x00007F01.
  - JAL mem_to_reg=10, pc+4=0x104 -> data 0x104.
- Divider result rd=7, 0xDEAD pushed while the pipeline is idle -> written next cycle. rd=0 result -> accepted, never written.
- Divider result pending plus continuous pipeline writes:
  - 4 starved cycles -> stall_o=1 for one cycle, rd=7 written.
  - The held instruction writes in the following cycle, exactly once.
- Two divider results fill the FIFO during a pipeline write:
  - div_ready_o=0, DRAIN for 2 cycles, both written in FIFO order.
  - div_ready_o returns to 1 afterwards.
- rst pulsed mid-DRAIN with 2 entries -> next cycle FIFO empty, stall_o=0, no write of the discarded entries.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load extraction, write-back
// source select, and arbitration of the single register-file write port
// between in-order pipeline results and buffered divider results.
module wb_stage #(
  parameter int XLEN         = 32,
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid_i,
  input  logic            mem_reg_write_i,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic [1:0]      mem_to_reg_i,
  input  logic [XLEN-1:0] mem_alu_result_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic [XLEN-1:0] mem_pc_plus_4_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic            div_valid_i,
  input  logic [4:0]      div_rd_addr_i,
  input  logic [XLEN-1:0] div_result_i,
  output logic            div_ready_o,
  output logic            stall_o,
  output logic            wb_reg_write_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic [XLEN-1:0] wb_data_o
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {S_NORMAL, S_DRAIN} state_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } lq_ent_t;

  // MEM/WB pipeline register
  logic            r_vld;
  logic            r_we;
  logic [4:0]      r_rd;
  logic [1:0]      r_sel;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] r_pc4;
  logic [2:0]      r_f3;

  // divider result FIFO
  lq_ent_t         r_lq [LQ_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW:0]     r_cnt;

  // arbitration control
  state_t          r_state;
  logic [SW-1:0]   r_starve;

  logic            w_pipe_wr;
  logic            w_normal;
  logic            w_empty;
  logic            w_full;
  logic            w_sel_pipe;
  logic            w_pop;
  logic            w_push;
  logic [SW-1:0]   w_starve_inc;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_result;

  assign w_pipe_wr    = r_vld & r_we & (r_rd != 5'd0);
  assign w_normal     = (r_state == S_NORMAL);
  assign w_empty      = (r_cnt == '0);
  assign w_full       = (r_cnt == (PW+1)'(LQ_DEPTH));
  // The pipeline owns the port in NORMAL; otherwise the FIFO head drains.
  assign w_sel_pipe   = w_normal & w_pipe_wr;
  assign w_pop        = ~w_sel_pipe & ~w_empty;
  // rd=0 divider results are handshaken but dropped.
  assign w_push       = div_valid_i & div_ready_o & (div_rd_addr_i != 5'd0);
  assign w_starve_inc = r_starve + SW'(1);

  assign div_ready_o  = ~w_full & w_normal & ~rst;
  assign stall_o      = ~w_normal;

  assign w_byte = r_rdata[{r_alu[1:0], 3'b000} +: 8];
  assign w_half = r_rdata[{r_alu[1], 4'b0000} +: 16];

  // Load extraction and write-back source select
  always_comb begin
    w_load = r_rdata;
    case (r_f3)
      3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = r_rdata;
    endcase
    case (r_sel)
      2'b01:   w_result = w_load;
      2'b10:   w_result = r_pc4;
      default: w_result = r_alu;
    endcase
  end

  // Register-file write port: pipeline first, then FIFO head, else idle
  always_comb begin
    wb_reg_write_o = 1'b0;
    wb_rd_addr_o   = 5'd0;
    wb_data_o      = '0;
    if (w_sel_pipe) begin
      wb_reg_write_o = 1'b1;
      wb_rd_addr_o   = r_rd;
      wb_data_o      = w_result;
    end else if (!w_empty) begin
      wb_reg_write_o = 1'b1;
      wb_rd_addr_o   = r_lq[r_rptr].rd;
      wb_data_o      = r_lq[r_rptr].data;
    end
  end

  // MEM/WB register: advances unless the stage is draining
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= 1'b0;
      r_we    <= 1'b0;
      r_rd    <= 5'd0;
      r_sel   <= 2'b00;
      r_alu   <= '0;
      r_rdata <= '0;
      r_pc4   <= '0;
      r_f3    <= 3'b000;
    end else if (!stall_o) begin
      r_vld   <= mem_valid_i;
      r_we    <= mem_reg_write_i;
      r_rd    <= mem_rd_addr_i;
      r_sel   <= mem_to_reg_i;
      r_alu   <= mem_alu_result_i;
      r_rdata <= mem_rdata_i;
      r_pc4   <= mem_pc_plus_4_i;
      r_f3    <= mem_funct3_i;
    end
  end

  // Divider FIFO storage; contents need no reset, occupancy guards them
  always_ff @(posedge clk) begin
    if (w_push) r_lq[r_wptr] <= '{rd: div_rd_addr_i, data: div_result_i};
  end

  // Divider FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Starvation tracking and NORMAL/DRAIN sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_NORMAL;
      r_starve <= '0;
    end else begin
      case (r_state)
        S_NORMAL: begin
          if (w_pipe_wr && !w_empty) begin
            // full FIFO behind a pipeline write, or too long starved: drain
            if (w_starve_inc == SW'(STARVE_LIMIT) || w_full) begin
              r_state  <= S_DRAIN;
              r_starve <= '0;
            end else begin
              r_starve <= w_starve_inc;
            end
          end else begin
            r_starve <= '0;
          end
        end
        S_DRAIN: begin
          // no pushes while draining, so the last pop ends the drain
          if (w_pop && r_cnt == (PW+1)'(1)) r_state <= S_NORMAL;
        end
        default: r_state <= S_NORMAL;
      endcase
    end
  end

endmodule
